alu_muldiv_seq: RTL

- Iterative, parametrised multiply/divide unit that extends the combinational integer ALU with the RV32M operations.
- Sits beside the ALU in the execute stage.
- Accepts one operation per valid/ready handshake, computes it over multiple cycles in a radix-2 shift/add-subtract datapath, and returns a registered result with a one-cycle valid pulse.
- The control unit stalls the pipeline while o_ready is low.

---
 rtl/alu_muldiv_pkg.sv | 37 +++
 rtl/muldiv_iter_core.sv | 64 ++++++
 rtl/alu_muldiv_seq.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_pkg.sv
// Shared types and op decode helpers for the iterative RV32M multiply/divide unit.
package alu_muldiv_pkg;

  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  function automatic logic is_div(op_e op);
    return op inside {OpDiv, OpDivu, OpRem, OpRemu};
  endfunction

  function automatic logic is_rem(op_e op);
    return op inside {OpRem, OpRemu};
  endfunction

  function automatic logic is_signed_a(op_e op);
    return op inside {OpMulh, OpMulhsu, OpDiv, OpRem};
  endfunction

  function automatic logic is_signed_b(op_e op);
    return op inside {OpMulh, OpDiv, OpRem};
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Radix-2 iteration datapath: shift-add multiply or restoring divide over one shared
// 2*WIDTH accumulator, one step per cycle for WIDTH cycles after start.
module muldiv_iter_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               div_mode_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               last_o,
  output logic [2*WIDTH-1:0] acc_d_o
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   b_q;
  logic [CntW-1:0]    cnt_q;
  logic               div_q;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH+1:0]   rem_diff;
  logic [2*WIDTH-1:0] acc_step;

  // Multiply: acc = {partial high, remaining multiplier bits}, shifted right each step.
  // Divide:   acc = {remainder, dividend bits becoming quotient bits}, shifted left.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_diff  = {1'b0, rem_shift} - {2'b00, b_q};
    acc_step  = acc_q;
    if (!div_q) begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end else if (!rem_diff[WIDTH+1]) begin
      acc_step = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  assign acc_d_o = acc_step;
  assign last_o  = (cnt_q == CntW'(1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      div_q <= 1'b0;
    end else if (start_i) begin
      acc_q <= {{WIDTH{1'b0}}, a_i};
      b_q   <= b_i;
      cnt_q <= CntW'(WIDTH);
      div_q <= div_mode_i;
    end else if (cnt_q != '0) begin
      acc_q <= acc_step;
      cnt_q <= cnt_q - CntW'(1);
    end
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Iterative RV32M multiply/divide unit: handshake FSM, sign pre/post-processing,
// divide fast paths and result select around muldiv_iter_core.
module alu_muldiv_seq
  import alu_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_operand_a,
  input  logic [WIDTH-1:0] i_operand_b,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result
);

  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

  state_e             state_q;
  op_e                op_q;
  logic               neg_q;
  logic               ready_q;
  logic               valid_q;
  logic [WIDTH-1:0]   result_q;

  op_e                op_in;
  logic               sign_a;
  logic               sign_b;
  logic               neg_in;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               div_zero;
  logic               div_ovf;
  logic               fast_path;
  logic [WIDTH-1:0]   fast_res;
  logic               accept;
  logic               core_start;
  logic               core_last;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   calc_res;

  assign op_in  = op_e'(i_op);
  assign sign_a = is_signed_a(op_in) & i_operand_a[WIDTH-1];
  assign sign_b = is_signed_b(op_in) & i_operand_b[WIDTH-1];
  assign mag_a  = sign_a ? -i_operand_a : i_operand_a;
  assign mag_b  = sign_b ? -i_operand_b : i_operand_b;
  // Remainder takes the dividend's sign; quotient and products take the XOR.
  assign neg_in = is_rem(op_in) ? sign_a : (sign_a ^ sign_b);

  assign div_zero  = is_div(op_in) && (i_operand_b == '0);
  assign div_ovf   = is_div(op_in) && is_signed_a(op_in) &&
                     (i_operand_a == MinNeg) && (i_operand_b == '1);
  assign fast_path = div_zero || div_ovf;

  always_comb begin
    fast_res = '0;
    if (div_zero) begin
      fast_res = is_rem(op_in) ? i_operand_a : '1;
    end else if (div_ovf) begin
      fast_res = is_rem(op_in) ? '0 : i_operand_a;
    end
  end

  assign accept     = (state_q == StIdle) && i_valid;
  assign core_start = accept && !fast_path;

  muldiv_iter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk_i      (i_clk),
    .reset_i    (i_reset),
    .start_i    (core_start),
    .div_mode_i (is_div(op_in)),
    .a_i        (mag_a),
    .b_i        (mag_b),
    .last_o     (core_last),
    .acc_d_o    (acc_d)
  );

  // Uses the core's final-step value so the result registers on the edge entering DONE.
  always_comb begin
    prod_fix = neg_q ? -acc_d : acc_d;
    quot_fix = neg_q ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
    rem_fix  = neg_q ? -acc_d[2*WIDTH-1:WIDTH] : acc_d[2*WIDTH-1:WIDTH];
    case (op_q)
      OpMul:                     calc_res = acc_d[WIDTH-1:0];
      OpMulh, OpMulhsu, OpMulhu: calc_res = prod_fix[2*WIDTH-1:WIDTH];
      OpDiv, OpDivu:             calc_res = quot_fix;
      OpRem, OpRemu:             calc_res = rem_fix;
      default:                   calc_res = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= StIdle;
      op_q     <= OpMul;
      neg_q    <= 1'b0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            op_q    <= op_in;
            neg_q   <= neg_in;
            ready_q <= 1'b0;
            if (fast_path) begin
              state_q  <= StDone;
              valid_q  <= 1'b1;
              result_q <= fast_res;
            end else begin
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          if (core_last) begin
            state_q  <= StDone;
            valid_q  <= 1'b1;
            result_q <= calc_res;
          end
        end
        StDone: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready  = ready_q;
  assign o_valid  = valid_q;
  assign o_result = result_q;

endmodule
